// File: rtl/axi_stream_packet_info_length_stripper_pkg.sv
// Shared header definitions for the packet length/info prepender and stripper.
// Header word 0 carries an 8-bit source ID and a 24-bit payload length in words.
package axis_pkt_info_pkg;

  localparam int ID_W      = 8;
  localparam int LEN_W     = 24;
  localparam int DATA_W    = 32;
  localparam int HDR_WORDS = 3;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } len_word_t;

  function automatic logic [DATA_W-1:0] bswap32(input logic [DATA_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [DATA_W-1:0] pack_len_word(input logic [ID_W-1:0] id,
                                                      input logic [LEN_W-1:0] len,
                                                      input logic swap);
    logic [DATA_W-1:0] w;
    w = {id, len};
    return swap ? bswap32(w) : w;
  endfunction

  function automatic len_word_t unpack_len_word(input logic [DATA_W-1:0] w,
                                                input logic swap);
    logic [DATA_W-1:0] n;
    n = swap ? bswap32(w) : w;
    return len_word_t'(n);
  endfunction

endpackage

// File: rtl/axi_stream_packet_info_length_stripper.sv
// Strips the 3-word ID/length/info header from AXI-Stream packets and regenerates tlast
// from the header length. Optional counters: define AXIS_INFO_STRIPPER_STATS_EN.
module axi_stream_packet_info_length_stripper
  import axis_pkt_info_pkg::*;
#(
  parameter logic [ID_W-1:0] ID          = '0,
  parameter bit              CHECK_ID    = 1'b1,
  parameter bit              ENDIAN_SWAP = 1'b0,
  parameter int unsigned     MAX_PKT_LEN = 368
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      in_tdata,
  input  logic                   in_tlast,
  input  logic                   in_tvalid,
  output logic                   in_tready,
  output logic [DATA_W-1:0]      out_tdata,
  output logic                   out_tlast,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [ID_W-1:0]        hdr_id,
  output logic [LEN_W-1:0]       hdr_len,
  output logic [1:0][DATA_W-1:0] hdr_info,
  output logic                   hdr_valid,
  output logic                   err_hdr,
  output logic                   err_short,
  output logic                   err_long
`ifdef AXIS_INFO_STRIPPER_STATS_EN
  ,
  output logic [31:0]            pkt_cnt,
  output logic [31:0]            err_cnt
`endif
);

  typedef enum logic [2:0] {ST_LEN, ST_INFO0, ST_INFO1, ST_PAY, ST_DROP} state_t;

  state_t                   r_state;
  logic                     r_run;
  logic [LEN_W-1:0]         r_cnt;
  logic [DATA_W-1:0]        r_out_tdata;
  logic                     r_out_tlast;
  logic                     r_out_tvalid;
  logic [ID_W-1:0]          r_hdr_id;
  logic [LEN_W-1:0]         r_hdr_len;
  logic [1:0][DATA_W-1:0]   r_hdr_info;
  logic                     r_hdr_valid;
  logic                     r_err_hdr;
  logic                     r_err_short;
  logic                     r_err_long;

  len_word_t                w_len_word;
  logic [DATA_W-1:0]        w_info;
  logic [LEN_W-1:0]         w_cnt_next;
  logic                     w_hdr_bad;
  logic                     w_in_fire;

  assign w_len_word = unpack_len_word(in_tdata, ENDIAN_SWAP);
  assign w_info     = ENDIAN_SWAP ? bswap32(in_tdata) : in_tdata;
  assign w_cnt_next = r_cnt + 1'b1;
  assign w_hdr_bad  = (w_len_word.len == '0) ||
                      ({{(32-LEN_W){1'b0}}, w_len_word.len} > 32'(MAX_PKT_LEN)) ||
                      (CHECK_ID && (w_len_word.id != ID));

  // Only payload words can back-pressure; header words are always consumed.
  assign in_tready = r_run && ((r_state != ST_PAY) || !r_out_tvalid || out_tready);
  assign w_in_fire = in_tvalid && in_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_LEN;
      r_run        <= 1'b0;
      r_cnt        <= '0;
      r_out_tdata  <= '0;
      r_out_tlast  <= 1'b0;
      r_out_tvalid <= 1'b0;
      r_hdr_id     <= '0;
      r_hdr_len    <= '0;
      r_hdr_info   <= '0;
      r_hdr_valid  <= 1'b0;
      r_err_hdr    <= 1'b0;
      r_err_short  <= 1'b0;
      r_err_long   <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      r_hdr_valid <= 1'b0;
      r_err_hdr   <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      if (out_tready) begin
        r_out_tvalid <= 1'b0;
      end
      case (r_state)
        ST_LEN: begin
          if (w_in_fire) begin
            r_hdr_id  <= w_len_word.id;
            r_hdr_len <= w_len_word.len;
            if (in_tlast || w_hdr_bad) begin
              r_err_hdr <= 1'b1;
              r_state   <= in_tlast ? ST_LEN : ST_DROP;
            end else begin
              r_state <= ST_INFO0;
            end
          end
        end
        ST_INFO0: begin
          if (w_in_fire) begin
            r_hdr_info[0] <= w_info;
            if (in_tlast) begin
              r_err_hdr <= 1'b1;
              r_state   <= ST_LEN;
            end else begin
              r_state <= ST_INFO1;
            end
          end
        end
        ST_INFO1: begin
          if (w_in_fire) begin
            r_hdr_info[1] <= w_info;
            if (in_tlast) begin
              r_err_hdr <= 1'b1;
              r_state   <= ST_LEN;
            end else begin
              r_hdr_valid <= 1'b1;
              r_cnt       <= '0;
              r_state     <= ST_PAY;
            end
          end
        end
        ST_PAY: begin
          if (w_in_fire) begin
            r_out_tvalid <= 1'b1;
            r_out_tdata  <= in_tdata;
            r_cnt        <= w_cnt_next;
            if (in_tlast) begin
              r_out_tlast <= 1'b1;
              r_err_short <= (w_cnt_next != r_hdr_len);
              r_state     <= ST_LEN;
            end else if (w_cnt_next == r_hdr_len) begin
              // Length reached without tlast: close the packet here, discard the rest.
              r_out_tlast <= 1'b1;
              r_err_long  <= 1'b1;
              r_state     <= ST_DROP;
            end else begin
              r_out_tlast <= 1'b0;
            end
          end
        end
        ST_DROP: begin
          if (w_in_fire && in_tlast) begin
            r_state <= ST_LEN;
          end
        end
        default: r_state <= ST_LEN;
      endcase
    end
  end

  assign out_tdata  = r_out_tdata;
  assign out_tlast  = r_out_tlast;
  assign out_tvalid = r_out_tvalid;
  assign hdr_id     = r_hdr_id;
  assign hdr_len    = r_hdr_len;
  assign hdr_info   = r_hdr_info;
  assign hdr_valid  = r_hdr_valid;
  assign err_hdr    = r_err_hdr;
  assign err_short  = r_err_short;
  assign err_long   = r_err_long;

`ifdef AXIS_INFO_STRIPPER_STATS_EN
  logic        r_out_legal;
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_err_cnt;

  // A packet counts only when its final word matched the header length exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_legal <= 1'b0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      if ((r_state == ST_PAY) && w_in_fire) begin
        r_out_legal <= in_tlast && (w_cnt_next == r_hdr_len);
      end
      if (r_out_tvalid && out_tready && r_out_tlast && r_out_legal) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
      if (r_err_hdr || r_err_short || r_err_long) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign pkt_cnt = r_pkt_cnt;
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_axi_stream_packet_info_length_stripper.sv
// Randomized scoreboard bench for the header stripper: a packet-level model predicts
// payload words, header captures and error pulses; a negedge monitor checks them.
module tb_axi_stream_packet_info_length_stripper;

  localparam int          MAXL  = 16;
  localparam logic [7:0]  MY_ID = 8'h05;

  typedef logic [31:0] wq_t[$];

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]      in_tdata;
  logic             in_tlast, in_tvalid, in_tready;
  logic [31:0]      out_tdata;
  logic             out_tlast, out_tvalid, out_tready;
  logic [7:0]       hdr_id;
  logic [23:0]      hdr_len;
  logic [1:0][31:0] hdr_info;
  logic             hdr_valid, err_hdr, err_short, err_long;

  logic [31:0]      s_in_tdata;
  logic             s_in_tlast, s_in_tvalid, s_in_tready;
  logic [31:0]      s_out_tdata;
  logic             s_out_tlast, s_out_tvalid, s_out_tready;
  logic [7:0]       s_hdr_id;
  logic [23:0]      s_hdr_len;
  logic [1:0][31:0] s_hdr_info;
  logic             s_hdr_valid, s_err_hdr, s_err_short, s_err_long;

  axi_stream_packet_info_length_stripper #(
    .ID(MY_ID), .CHECK_ID(1'b1), .ENDIAN_SWAP(1'b0), .MAX_PKT_LEN(MAXL)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .hdr_id(hdr_id), .hdr_len(hdr_len), .hdr_info(hdr_info), .hdr_valid(hdr_valid),
    .err_hdr(err_hdr), .err_short(err_short), .err_long(err_long)
  );

  axi_stream_packet_info_length_stripper #(
    .ID(MY_ID), .CHECK_ID(1'b1), .ENDIAN_SWAP(1'b1), .MAX_PKT_LEN(MAXL)
  ) u_swap (
    .clk(clk), .rst(rst),
    .in_tdata(s_in_tdata), .in_tlast(s_in_tlast), .in_tvalid(s_in_tvalid), .in_tready(s_in_tready),
    .out_tdata(s_out_tdata), .out_tlast(s_out_tlast), .out_tvalid(s_out_tvalid), .out_tready(s_out_tready),
    .hdr_id(s_hdr_id), .hdr_len(s_hdr_len), .hdr_info(s_hdr_info), .hdr_valid(s_hdr_valid),
    .err_hdr(s_err_hdr), .err_short(s_err_short), .err_long(s_err_long)
  );

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;  // 0 random, 1 toggle, 2 always ready, 3 never ready

  logic [32:0] exp_out_q[$];
  logic [95:0] exp_hdr_q[$];
  int          exp_err_q[$];  // 1 hdr, 2 short, 3 long

  logic [32:0] s_got_q[$];
  logic [95:0] s_hdr_cap;
  int          s_hdr_seen = 0;
  int          s_err_seen = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic fail_unexp(input string name, input logic [95:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h want nothing", name, act);
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic wq_t mk(input logic [7:0] id, input logic [23:0] len,
                             input logic [31:0] i0, input logic [31:0] i1,
                             input int npay, input bit rnd);
    wq_t q;
    q.push_back({id, len});
    q.push_back(i0);
    q.push_back(i1);
    for (int i = 0; i < npay; i++) q.push_back(rnd ? $urandom : 32'(i + 1));
    return q;
  endfunction

  // Packet-level reference: header validity, then min(payload, len) words forwarded.
  task automatic model(input wq_t w);
    int n, p, k, len_i;
    logic [7:0]  id;
    logic [23:0] len;
    n = w.size();
    id = w[0][31:24];
    len = w[0][23:0];
    len_i = int'(len);
    if (len_i == 0 || len_i > MAXL || id != MY_ID || n <= 3) begin
      exp_err_q.push_back(1);
    end else begin
      exp_hdr_q.push_back({id, len, w[2], w[1]});
      p = n - 3;
      k = (p < len_i) ? p : len_i;
      for (int i = 0; i < k; i++) exp_out_q.push_back({(i == k - 1), w[3 + i]});
      if (p < len_i) exp_err_q.push_back(2);
      else if (p > len_i) exp_err_q.push_back(3);
    end
  endtask

  task automatic send_words(input wq_t w, input int cnt);
    int t;
    for (int i = 0; i < cnt; i++) begin
      if (rdy_mode == 0 && ($urandom % 3) == 0) begin
        in_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      in_tvalid = 1'b1;
      in_tdata  = w[i];
      in_tlast  = (i == w.size() - 1);
      for (t = 0; t < 200; t++) begin
        @(negedge clk);
        if (in_tready) break;
      end
      if (t == 200) begin
        fail_unexp("in_handshake_timeout", 96'(i));
        finish_now();
      end
      @(posedge clk); #1;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input wq_t w);
    model(w);
    send_words(w, w.size());
  endtask

  task automatic drain();
    for (int t = 0; t < 1000 && (exp_out_q.size() != 0 || exp_err_q.size() != 0 ||
                                 exp_hdr_q.size() != 0); t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Downstream ready generator.
  initial begin
    out_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_tready = ($urandom % 4) != 0;
        1:       out_tready = ~out_tready;
        2:       out_tready = 1'b1;
        default: out_tready = 1'b0;
      endcase
    end
  end

  // Main scoreboard monitor.
  initial begin
    logic        held_pending;
    logic [32:0] held_word;
    int          nerr, code;
    held_pending = 1'b0;
    held_word    = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        held_pending = 1'b0;
      end else begin
        if (held_pending) begin
          chk("hold_valid", 96'(out_tvalid), 96'(1));
          chk("hold_data", 96'({out_tlast, out_tdata}), 96'(held_word));
        end
        if (out_tvalid && out_tready) begin
          if (exp_out_q.size() == 0) fail_unexp("unexpected_out", 96'({out_tlast, out_tdata}));
          else chk("out_word", 96'({out_tlast, out_tdata}), 96'(exp_out_q.pop_front()));
        end
        held_pending = out_tvalid && !out_tready;
        held_word    = {out_tlast, out_tdata};
        nerr = int'(err_hdr) + int'(err_short) + int'(err_long);
        if (nerr > 1) fail_unexp("err_overlap", 96'({err_hdr, err_short, err_long}));
        else if (nerr == 1) begin
          code = err_hdr ? 1 : (err_short ? 2 : 3);
          if (exp_err_q.size() == 0) fail_unexp("unexpected_err", 96'(code));
          else chk("err_kind", 96'(code), 96'(exp_err_q.pop_front()));
        end
        if (hdr_valid) begin
          if (exp_hdr_q.size() == 0) fail_unexp("unexpected_hdr", 96'({hdr_id, hdr_len}));
          else chk("hdr_fields", {hdr_id, hdr_len, hdr_info[1], hdr_info[0]}, exp_hdr_q.pop_front());
        end
      end
    end
  end

  // Capture for the byte-swapped instance.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (s_out_tvalid && s_out_tready) s_got_q.push_back({s_out_tlast, s_out_tdata});
        if (s_hdr_valid) begin
          s_hdr_seen++;
          s_hdr_cap = {s_hdr_id, s_hdr_len, s_hdr_info[1], s_hdr_info[0]};
        end
        if (s_err_hdr || s_err_short || s_err_long) s_err_seen++;
      end
    end
  end

  initial begin
    wq_t w;
    int  cls, len, np;
    logic [31:0] s_words [0:6];
    int  t;

    in_tdata = '0; in_tlast = 1'b0; in_tvalid = 1'b0;
    s_in_tdata = '0; s_in_tlast = 1'b0; s_in_tvalid = 1'b0; s_out_tready = 1'b1;
    s_hdr_cap = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_out_tvalid", 96'(out_tvalid), 96'(0));
    chk("rst_in_tready", 96'(in_tready), 96'(0));
    chk("rst_hdr", 96'({hdr_id, hdr_len, hdr_info}), 96'(0));
    chk("rst_pulses", 96'({hdr_valid, err_hdr, err_short, err_long}), 96'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    rdy_mode = 2;
    send_pkt(mk(8'h05, 24'd4, 32'hAAAA0000, 32'hBBBB1111, 4, 1'b0));
    send_pkt(mk(8'h05, 24'd4, 32'hAAAA0000, 32'hBBBB1111, 2, 1'b0));
    send_pkt(mk(8'h05, 24'd4, 32'h0000AAAA, 32'h1111BBBB, 4, 1'b0));
    send_pkt(mk(8'h05, 24'd2, 32'h1, 32'h2, 5, 1'b0));
    send_pkt(mk(8'h07, 24'd4, 32'h3, 32'h4, 4, 1'b0));
    send_pkt(mk(8'h05, 24'd3, 32'h5, 32'h6, 3, 1'b0));
    send_pkt(mk(8'h05, 24'd0, 32'h7, 32'h8, 2, 1'b0));
    send_pkt(mk(8'h05, 24'(MAXL), 32'h9, 32'hA, MAXL, 1'b1));
    send_pkt(mk(8'h05, 24'(MAXL + 1), 32'hB, 32'hC, MAXL + 1, 1'b1));
    for (int n = 1; n <= 3; n++) begin
      w = mk(8'h05, 24'd2, 32'hD, 32'hE, 0, 1'b0);
      while (w.size() > n) void'(w.pop_back());
      send_pkt(w);
    end
    drain();
    rdy_mode = 1;
    send_pkt(mk(8'h05, 24'd6, 32'h600D0000, 32'h600D0001, 6, 1'b1));
    drain();

    // Randomized traffic.
    rdy_mode = 0;
    for (int p = 0; p < 60; p++) begin
      cls = $urandom % 10;
      if (cls < 5) begin
        len = 1 + $urandom % 8;
        w = mk(MY_ID, 24'(len), $urandom, $urandom, len, 1'b1);
      end else if (cls == 5) begin
        len = 2 + $urandom % 7;
        np = 1 + $urandom % (len - 1);
        w = mk(MY_ID, 24'(len), $urandom, $urandom, np, 1'b1);
      end else if (cls == 6) begin
        len = 1 + $urandom % 5;
        w = mk(MY_ID, 24'(len), $urandom, $urandom, len + 1 + $urandom % 4, 1'b1);
      end else if (cls == 7) begin
        w = mk(MY_ID ^ 8'(1 + $urandom % 255), 24'd3, $urandom, $urandom, 3, 1'b1);
      end else if (cls == 8) begin
        len = ($urandom % 2 == 0) ? 0 : MAXL + 1 + $urandom % 1000;
        w = mk(MY_ID, 24'(len), $urandom, $urandom, 1 + $urandom % 4, 1'b1);
      end else begin
        w = mk(MY_ID, 24'd2, $urandom, $urandom, 0, 1'b1);
        np = 1 + $urandom % 3;
        while (w.size() > np) void'(w.pop_back());
      end
      send_pkt(w);
    end
    rdy_mode = 2;
    drain();
    chk("drain_out_q", 96'(exp_out_q.size()), 96'(0));
    chk("drain_err_q", 96'(exp_err_q.size()), 96'(0));
    chk("drain_hdr_q", 96'(exp_hdr_q.size()), 96'(0));

    // Byte-swapped header instance.
    s_words[0] = 32'h04000005; s_words[1] = 32'h78563412; s_words[2] = 32'hBBBB1111;
    s_words[3] = 32'h11; s_words[4] = 32'h22; s_words[5] = 32'h33; s_words[6] = 32'h44;
    for (int i = 0; i < 7; i++) begin
      s_in_tvalid = 1'b1;
      s_in_tdata  = s_words[i];
      s_in_tlast  = (i == 6);
      for (t = 0; t < 200; t++) begin
        @(negedge clk);
        if (s_in_tready) break;
      end
      if (t == 200) begin
        fail_unexp("swap_handshake_timeout", 96'(i));
        finish_now();
      end
      @(posedge clk); #1;
    end
    s_in_tvalid = 1'b0;
    s_in_tlast  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("swap_hdr_count", 96'(s_hdr_seen), 96'(1));
    chk("swap_hdr_fields", s_hdr_cap, {8'h05, 24'd4, 32'h1111BBBB, 32'h12345678});
    chk("swap_err_count", 96'(s_err_seen), 96'(0));
    chk("swap_out_count", 96'(s_got_q.size()), 96'(4));
    for (int i = 0; i < 4 && i < s_got_q.size(); i++)
      chk("swap_out_word", 96'(s_got_q[i]), 96'({(i == 3), s_words[3 + i]}));

    // Reset in the middle of a payload with a word pending in the output register.
    rdy_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    w = mk(MY_ID, 24'd8, 32'hCAFE0000, 32'hCAFE0001, 8, 1'b1);
    exp_hdr_q.push_back({w[0], w[2], w[1]});
    send_words(w, 4);
    chk("pend_before_rst", 96'(out_tvalid), 96'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_out_tvalid", 96'(out_tvalid), 96'(0));
    chk("mid_rst_hdr_len", 96'(hdr_len), 96'(0));
    chk("mid_rst_in_tready", 96'(in_tready), 96'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rdy_mode = 2;
    send_pkt(mk(8'h05, 24'd4, 32'hAAAA0000, 32'hBBBB1111, 4, 1'b0));
    drain();
    chk("final_out_q", 96'(exp_out_q.size()), 96'(0));
    chk("final_err_q", 96'(exp_err_q.size()), 96'(0));
    chk("final_hdr_q", 96'(exp_hdr_q.size()), 96'(0));
    finish_now();
  end

endmodule
